// File: rtl/sub_slice_pkg.sv
// Shared definitions for the serial 3-bit-slice subtractor and its slice cell.
package sub_slice_pkg;

    localparam int SLICE = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [SLICE-1:0] slice_t;

endpackage

// File: rtl/sub_slice3.sv
// Combinational 3-bit subtractor cell: d = x - y - bi, bo is the borrow out.
module sub_slice3
    import sub_slice_pkg::*;
(
    input  slice_t x,
    input  slice_t y,
    input  logic   bi,
    output slice_t d,
    output logic   bo
);

    logic [SLICE:0] t;

    // One extra bit wide so the wrap-around lands in t[SLICE] as the borrow.
    assign t  = {1'b0, x} - {1'b0, y} - {{SLICE{1'b0}}, bi};
    assign d  = t[SLICE-1:0];
    assign bo = t[SLICE];

endmodule

// File: rtl/serial_subtractor_slice3.sv
// Multi-cycle unsigned subtractor: A - B - bin, one 3-bit slice per clock with a registered borrow.
module serial_subtractor_slice3
    import sub_slice_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    generate
        if (WIDTH <= 0 || (WIDTH % SLICE) != 0) begin : g_bad_width
            $error("WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic [31:0] base;
    slice_t      x_s, y_s, d_s;
    logic        bo_s;

    assign base = 32'(k_q) * SLICE;
    assign x_s  = a_q[base +: SLICE];
    assign y_s  = b_q[base +: SLICE];

    sub_slice3 u_slice (
        .x  (x_s),
        .y  (y_s),
        .bi (borrow_q),
        .d  (d_s),
        .bo (bo_s)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    k_d      = '0;
                    diff_d   = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                diff_d[base +: SLICE] = d_s;
                borrow_d = bo_s;
                if (k_q == K_LAST) begin
                    bout_d  = bo_s;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor_slice3.sv
// Directed-vector and randomized bench for serial_subtractor_slice3 at WIDTH=12.
module tb_serial_subtractor_slice3;

    localparam int W = 12;
    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
    } vec_t;

    vec_t vecs[9];

    serial_subtractor_slice3 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer operands at a negedge and hold until accepted; returns after the accept edge.
    task automatic start_txn(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        bin      = bv_in;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom);
    endtask

    // Count rising edges after the accept edge until out_valid, tracking in_ready meanwhile.
    task automatic wait_done(output int edges, output bit ready_seen);
        edges      = 0;
        ready_seen = 1'b0;
        @(negedge clk);
        while (!out_valid && edges < 20) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (in_ready) ready_seen = 1'b1;
        if (!out_valid) check("done_timeout", 1, 0);
    endtask

    task automatic finish_txn();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    int           edges;
    bit           ready_seen;
    logic [W-1:0] held_diff;
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         rbin;

    initial begin
        vecs[0] = '{12'h123, 12'h001, 1'b0, 12'h122, 1'b0};
        vecs[1] = '{12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1};
        vecs[2] = '{12'h800, 12'h7FF, 1'b1, 12'h000, 1'b0};
        vecs[3] = '{12'h555, 12'h555, 1'b1, 12'hFFF, 1'b1};
        vecs[4] = '{12'hFFF, 12'h000, 1'b1, 12'hFFE, 1'b0};
        vecs[5] = '{12'h000, 12'hFFF, 1'b0, 12'h001, 1'b1};
        vecs[6] = '{12'h0A5, 12'h05A, 1'b0, 12'h04B, 1'b0};
        vecs[7] = '{12'hFFF, 12'hFFF, 1'b0, 12'h000, 1'b0};
        vecs[8] = '{12'h000, 12'h000, 1'b1, 12'hFFF, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_diff", 32'(diff), 0);
        check("rst_bout", 32'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            start_txn(vecs[i].a, vecs[i].b, vecs[i].bin);
            check("run_busy", 32'(busy), 1);
            wait_done(edges, ready_seen);
            check("latency", 32'(edges), N);
            check("in_ready_low", 32'(ready_seen), 0);
            check("tbl_diff", 32'(diff), 32'(vecs[i].diff));
            check("tbl_bout", 32'(bout), 32'(vecs[i].bout));
            finish_txn();
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 1);
            check("idle_hold_diff", 32'(diff), 32'(vecs[i].diff));
        end

        // Backpressure in DONE with a competing offer that must be ignored
        start_txn(12'h456, 12'h123, 1'b0);
        wait_done(edges, ready_seen);
        held_diff = diff;
        check("bp_diff", 32'(diff), 32'h333);
        in_valid = 1'b1;
        a        = 12'h001;
        b        = 12'h002;
        bin      = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_diff_stable", 32'(diff), 32'(held_diff));
            check("bp_bout_stable", 32'(bout), 0);
        end
        in_valid = 1'b0;
        finish_txn();
        start_txn(12'h010, 12'h020, 1'b0);
        wait_done(edges, ready_seen);
        check("bp_next_diff", 32'(diff), 32'hFF0);
        check("bp_next_bout", 32'(bout), 1);
        finish_txn();

        // Asynchronous reset while RUN is on slice k=2
        start_txn(12'h123, 12'h001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_diff", 32'(diff), 0);
        check("arst_bout", 32'(bout), 0);
        check("arst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_txn(12'h00F, 12'h00E, 1'b0);
        wait_done(edges, ready_seen);
        check("post_rst_latency", 32'(edges), N);
        check("post_rst_diff", 32'(diff), 32'h001);
        check("post_rst_bout", 32'(bout), 0);
        finish_txn();

        // Random transactions against a widened-arithmetic model
        for (int t = 0; t < 1000; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            start_txn(ra, rb, rbin);
            wait_done(edges, ready_seen);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rnd_diff", 32'(diff), 32'(full[W-1:0]));
            check("rnd_bout", 32'(bout), 32'(full[W]));
            finish_txn();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
